vending_machine_sequencer: RTL and testbench

Next-state sequencer for the vending machine: owns the S2/S1/S0 state register that feeds `vending_machine_control_logic`, and consumes that block's A (accept coins) and P (pay out) decodes back as gating qualifiers. It tracks inserted credit in nickels, decides when the price is met, waits for the dispenser, then pays change one nickel per cycle. It sits between the coin mech / dispenser and the combinational output decoder.

---
 rtl/vending_pkg.sv | 40 ++++
 rtl/vending_credit_acc.sv | 38 +++
 rtl/vending_machine_sequencer.sv | 121 ++++++++++++
 tb/tb_vending_machine_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared state codes, coin encodings and credit ops for the vending sequencer
package vending_pkg;

    localparam int DEFAULT_PRICE = 7;

    // Codes are chosen so the downstream decoder yields the right A/P per state
    typedef enum logic [2:0] {
        ST_BOOT    = 3'b000,
        ST_IDLE    = 3'b011,
        ST_COLLECT = 3'b111,
        ST_VEND    = 3'b100,
        ST_CHANGE  = 3'b110
    } state_t;

    typedef enum logic [1:0] {
        COIN_NICKEL  = 2'b00,
        COIN_DIME    = 2'b01,
        COIN_QUARTER = 2'b10,
        COIN_INVALID = 2'b11
    } coin_t;

    typedef enum logic [2:0] {
        CR_HOLD     = 3'd0,
        CR_CLEAR    = 3'd1,
        CR_LOAD     = 3'd2,
        CR_ADD      = 3'd3,
        CR_ADD_VEND = 3'd4,
        CR_DEC      = 3'd5
    } credit_op_t;

    function automatic logic [2:0] coin_value(input logic [1:0] ct);
        case (ct)
            COIN_NICKEL:  coin_value = 3'd1;
            COIN_DIME:    coin_value = 3'd2;
            COIN_QUARTER: coin_value = 3'd5;
            default:      coin_value = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vending_credit_acc.sv
// rtl/vending_credit_acc.sv - credit register in nickels with add, vend, load, clear and decrement ops
module vending_credit_acc
    import vending_pkg::*;
#(
    parameter int PRICE    = DEFAULT_PRICE,
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  credit_op_t          op,
    input  logic [CREDIT_W-1:0] operand,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] sum
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

    always_comb begin
        sum = credit + operand;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= '0;
        end else begin
            case (op)
                CR_CLEAR:    credit <= '0;
                CR_LOAD:     credit <= operand;
                CR_ADD:      credit <= sum;
                CR_ADD_VEND: credit <= sum - PRICE_C;
                CR_DEC:      credit <= credit - ONE_C;
                default:     credit <= credit;
            endcase
        end
    end

endmodule

// File: rtl/vending_machine_sequencer.sv
// rtl/vending_machine_sequencer.sv - vending machine next-state sequencer driving the S2..S0 state code
module vending_machine_sequencer
    import vending_pkg::*;
#(
    parameter int PRICE    = DEFAULT_PRICE,
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    input  logic                dispense_done,
    input  logic                A,
    input  logic                P,
    output logic                S2,
    output logic                S1,
    output logic                S0,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                change_pulse
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

    state_t              state;
    state_t              next_state;
    credit_op_t          op;
    logic                coin_ok;
    logic [CREDIT_W-1:0] coin_nickels;
    logic [CREDIT_W-1:0] sum;

    assign {S2, S1, S0} = state;

    // A gates acceptance so a broken decoder cannot let coins in outside IDLE/COLLECT
    assign coin_ok      = coin_valid & A & (coin_type != COIN_INVALID);
    assign coin_nickels = CREDIT_W'(coin_value(coin_type));

    vending_credit_acc #(
        .PRICE    (PRICE),
        .CREDIT_W (CREDIT_W)
    ) u_credit_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .op      (op),
        .operand (coin_nickels),
        .credit  (credit),
        .sum     (sum)
    );

    always_comb begin
        next_state = state;
        op         = CR_HOLD;
        case (state)
            ST_BOOT: begin
                next_state = ST_IDLE;
                op         = CR_CLEAR;
            end
            ST_IDLE: begin
                if (coin_ok) begin
                    if (coin_nickels >= PRICE_C) begin
                        next_state = ST_VEND;
                        op         = CR_ADD_VEND;
                    end else begin
                        next_state = ST_COLLECT;
                        op         = CR_LOAD;
                    end
                end else begin
                    op = CR_CLEAR;
                end
            end
            ST_COLLECT: begin
                if (coin_ok && cancel) begin
                    // Coin arriving with cancel is refunded along with existing credit
                    next_state = ST_CHANGE;
                    op         = CR_ADD;
                end else if (coin_ok) begin
                    if (sum >= PRICE_C) begin
                        next_state = ST_VEND;
                        op         = CR_ADD_VEND;
                    end else begin
                        op = CR_ADD;
                    end
                end else if (cancel && credit != '0) begin
                    next_state = ST_CHANGE;
                end
            end
            ST_VEND: begin
                if (dispense_done && P) begin
                    next_state = (credit != '0) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (credit <= ONE_C) begin
                    next_state = ST_IDLE;
                    op         = CR_CLEAR;
                end else begin
                    op = CR_DEC;
                end
            end
            default: begin
                next_state = ST_BOOT;
                op         = CR_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_BOOT;
            coin_reject  <= 1'b0;
            change_pulse <= 1'b0;
        end else begin
            state        <= next_state;
            coin_reject  <= coin_valid & ~coin_ok;
            change_pulse <= (next_state == ST_CHANGE);
        end
    end

endmodule

// File: tb/tb_vending_machine_sequencer.sv
// tb/tb_vending_machine_sequencer.sv - table-driven bench for vending_machine_sequencer
module tb_vending_machine_sequencer;

    localparam logic [1:0] NI  = 2'b00;
    localparam logic [1:0] DI  = 2'b01;
    localparam logic [1:0] QU  = 2'b10;
    localparam logic [1:0] BAD = 2'b11;

    localparam logic [2:0] BOOT = 3'b000;
    localparam logic [2:0] IDLE = 3'b011;
    localparam logic [2:0] COLL = 3'b111;
    localparam logic [2:0] VEND = 3'b100;
    localparam logic [2:0] CHG  = 3'b110;

    typedef struct {
        logic       cv;
        logic [1:0] ct;
        logic       cn;
        logic       dd;
        logic       pb;
        logic [2:0] s;
        logic [3:0] cr;
        logic       rj;
        logic       ch;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic       cancel = 1'b0;
    logic       dispense_done = 1'b0;
    logic       p_break = 1'b0;
    logic       A, P;
    logic       S2, S1, S0;
    logic [3:0] credit;
    logic       coin_reject, change_pulse;

    int n_vec = 0;
    int n_err = 0;
    vec_t vq[$];

    // Reference decode of the control logic; p_break models a stuck-low P
    assign A = S1 & S0;
    assign P = S2 & ~S1 & ~S0 & ~p_break;

    always #5 clk = ~clk;

    vending_machine_sequencer #(.PRICE(7), .CREDIT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .coin_valid    (coin_valid),
        .coin_type     (coin_type),
        .cancel        (cancel),
        .dispense_done (dispense_done),
        .A             (A),
        .P             (P),
        .S2            (S2),
        .S1            (S1),
        .S0            (S0),
        .credit        (credit),
        .coin_reject   (coin_reject),
        .change_pulse  (change_pulse)
    );

    task automatic check(input string name, input logic [2:0] es, input logic [3:0] ec,
                         input logic er, input logic ep);
        n_vec++;
        if ({S2, S1, S0} !== es || credit !== ec || coin_reject !== er || change_pulse !== ep) begin
            n_err++;
            $display("FAIL %s: got S=%b credit=%0d rej=%b chg=%b, want S=%b credit=%0d rej=%b chg=%b",
                     name, {S2, S1, S0}, credit, coin_reject, change_pulse, es, ec, er, ep);
        end
    endtask

    task automatic add(input logic cv, input logic [1:0] ct, input logic cn, input logic dd,
                       input logic pb, input logic [2:0] s, input logic [3:0] cr,
                       input logic rj, input logic ch);
        vec_t v;
        v.cv = cv; v.ct = ct; v.cn = cn; v.dd = dd; v.pb = pb;
        v.s = s; v.cr = cr; v.rj = rj; v.ch = ch;
        vq.push_back(v);
    endtask

    task automatic drive(input logic cv, input logic [1:0] ct, input logic cn, input logic dd);
        coin_valid = cv; coin_type = ct; cancel = cn; dispense_done = dd;
    endtask

    initial begin
        // exact pay: dime + quarter
        add(1'b1, DI, 1'b0, 1'b0, 1'b0, COLL, 4'd2, 1'b0, 1'b0);
        add(1'b1, QU, 1'b0, 1'b0, 1'b0, VEND, 4'd0, 1'b0, 1'b0);
        add(1'b0, NI, 1'b0, 1'b1, 1'b0, IDLE, 4'd0, 1'b0, 1'b0);
        // overpay: quarter + quarter, three nickels back
        add(1'b1, QU, 1'b0, 1'b0, 1'b0, COLL, 4'd5, 1'b0, 1'b0);
        add(1'b1, QU, 1'b0, 1'b0, 1'b0, VEND, 4'd3, 1'b0, 1'b0);
        add(1'b0, NI, 1'b0, 1'b1, 1'b0, CHG,  4'd3, 1'b0, 1'b1);
        add(1'b0, NI, 1'b0, 1'b0, 1'b0, CHG,  4'd2, 1'b0, 1'b1);
        add(1'b0, NI, 1'b0, 1'b0, 1'b0, CHG,  4'd1, 1'b0, 1'b1);
        add(1'b0, NI, 1'b0, 1'b0, 1'b0, IDLE, 4'd0, 1'b0, 1'b0);
        // cancel after nickel + dime
        add(1'b1, NI, 1'b0, 1'b0, 1'b0, COLL, 4'd1, 1'b0, 1'b0);
        add(1'b1, DI, 1'b0, 1'b0, 1'b0, COLL, 4'd3, 1'b0, 1'b0);
        add(1'b0, NI, 1'b1, 1'b0, 1'b0, CHG,  4'd3, 1'b0, 1'b1);
        add(1'b0, NI, 1'b0, 1'b0, 1'b0, CHG,  4'd2, 1'b0, 1'b1);
        add(1'b0, NI, 1'b0, 1'b0, 1'b0, CHG,  4'd1, 1'b0, 1'b1);
        add(1'b0, NI, 1'b0, 1'b0, 1'b0, IDLE, 4'd0, 1'b0, 1'b0);
        // cancel together with a dime at credit 1
        add(1'b1, NI, 1'b0, 1'b0, 1'b0, COLL, 4'd1, 1'b0, 1'b0);
        add(1'b1, DI, 1'b1, 1'b0, 1'b0, CHG,  4'd3, 1'b0, 1'b1);
        add(1'b0, NI, 1'b0, 1'b0, 1'b0, CHG,  4'd2, 1'b0, 1'b1);
        add(1'b0, NI, 1'b0, 1'b0, 1'b0, CHG,  4'd1, 1'b0, 1'b1);
        add(1'b0, NI, 1'b0, 1'b0, 1'b0, IDLE, 4'd0, 1'b0, 1'b0);
        // rejects and ignored inputs
        add(1'b1, BAD, 1'b0, 1'b0, 1'b0, IDLE, 4'd0, 1'b1, 1'b0);
        add(1'b0, NI, 1'b0, 1'b0, 1'b0, IDLE, 4'd0, 1'b0, 1'b0);
        add(1'b0, NI, 1'b1, 1'b0, 1'b0, IDLE, 4'd0, 1'b0, 1'b0);
        add(1'b1, QU, 1'b0, 1'b0, 1'b0, COLL, 4'd5, 1'b0, 1'b0);
        add(1'b1, DI, 1'b0, 1'b0, 1'b0, VEND, 4'd0, 1'b0, 1'b0);
        add(1'b1, NI, 1'b0, 1'b0, 1'b0, VEND, 4'd0, 1'b1, 1'b0);
        add(1'b0, NI, 1'b1, 1'b0, 1'b0, VEND, 4'd0, 1'b0, 1'b0);
        add(1'b0, NI, 1'b0, 1'b1, 1'b1, VEND, 4'd0, 1'b0, 1'b0);
        add(1'b0, NI, 1'b0, 1'b1, 1'b0, IDLE, 4'd0, 1'b0, 1'b0);
        add(1'b1, NI, 1'b0, 1'b0, 1'b0, COLL, 4'd1, 1'b0, 1'b0);
        add(1'b1, BAD, 1'b0, 1'b0, 1'b0, COLL, 4'd1, 1'b1, 1'b0);
        add(1'b0, NI, 1'b1, 1'b0, 1'b0, CHG,  4'd1, 1'b0, 1'b1);
        add(1'b1, NI, 1'b0, 1'b0, 1'b0, IDLE, 4'd0, 1'b1, 1'b0);

        // reset asserted from time zero takes effect before any clock edge
        #2;
        check("reset_async", BOOT, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("boot_to_idle", IDLE, 4'd0, 1'b0, 1'b0);
        if (A !== 1'b1) begin
            n_err++;
            $display("FAIL idle_accept: got A=%b, want A=1", A);
        end
        n_vec++;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].cv, vq[i].ct, vq[i].cn, vq[i].dd);
            p_break = vq[i].pb;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vq[i].s, vq[i].cr, vq[i].rj, vq[i].ch);
        end

        // reset while paying change with credit 2
        p_break = 1'b0;
        drive(1'b1, QU, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rst_seq_q1", COLL, 4'd5, 1'b0, 1'b0);
        drive(1'b1, QU, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rst_seq_q2", VEND, 4'd3, 1'b0, 1'b0);
        drive(1'b0, NI, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("rst_seq_chg3", CHG, 4'd3, 1'b0, 1'b1);
        drive(1'b0, NI, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rst_seq_chg2", CHG, 4'd2, 1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_change", BOOT, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst_hold%0d", k), BOOT, 4'd0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_release", IDLE, 4'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rst_settled", IDLE, 4'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
